// File: rtl/insn_enc_loader.sv
// insn_enc_loader: encodes symbolic PU instructions into 16-bit words and
// writes them sequentially (from address 0) into instruction memory.
// LI16 is expanded into a LIL/LIH pair.
// Optional feature: define ENC_AUTOHALT_EN to append a HALT word when fin is
// seen (TAIL state); without it fin closes the program directly.
module insn_enc_loader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [1:0]    in_rw,
  input  logic [1:0]    in_ra,
  input  logic [1:0]    in_rb,
  input  logic [2:0]    in_op,
  input  logic [15:0]   in_imm,
  input  logic          fin,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [15:0]   im_wd,
  output logic [AW:0]   count,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

`ifdef ENC_AUTOHALT_EN
  typedef enum logic [1:0] {RUN, LI2, DONE, TAIL} state_t;
  localparam state_t END_ST = TAIL;
`else
  typedef enum logic [1:0] {RUN, LI2, DONE} state_t;
  localparam state_t END_ST = DONE;
`endif

  state_t        state_reg, state_next;
  logic          fin_pend_reg, fin_pend_next;
  logic [1:0]    li_rw_reg, li_rw_next;
  logic [7:0]    li_hi_reg, li_hi_next;
  logic          im_we_reg, we_next;
  logic [AW-1:0] im_addr_reg, addr_next;
  logic [15:0]   im_wd_reg, wd_next;
  logic [AW:0]   count_reg, count_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          in_ready_reg, ready_next;
  logic          acc;
  logic          full;

  assign in_ready = in_ready_reg;
  assign im_we    = im_we_reg;
  assign im_addr  = im_addr_reg;
  assign im_wd    = im_wd_reg;
  assign count    = count_reg;
  assign done     = done_reg;
  assign err      = err_reg;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next    = state_reg;
    fin_pend_next = fin_pend_reg;
    li_rw_next    = li_rw_reg;
    li_hi_next    = li_hi_reg;
    we_next       = 1'b0;
    wd_next       = im_wd_reg;
    err_next      = err_reg;
    acc           = in_valid && in_ready_reg;
    full          = (count_reg == FULL);

    case (state_reg)
      RUN: begin
        if (full) begin
          // Memory exhausted: close with error, nothing more is written.
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          if (acc) begin
            case (in_kind)
              3'd0: begin we_next = 1'b1; wd_next = 16'h0000; end
              3'd1: begin we_next = 1'b1; wd_next = 16'h0001; end
              3'd2: begin
                we_next = 1'b1;
                wd_next = {3'b000, 1'b0, in_rw, in_ra, 1'b0, in_op, 1'b0, 1'b1, in_rb};
              end
              3'd3: begin
                if (in_op[2:1] != 2'b00) begin
                  err_next = 1'b1;
                end else begin
                  we_next = 1'b1;
                  wd_next = {3'b001, in_op[0], in_rw, in_ra, in_imm[7:0]};
                end
              end
              3'd4: begin we_next = 1'b1; wd_next = {4'b0100, in_rw, in_ra, in_imm[7:0]}; end
              3'd5: begin we_next = 1'b1; wd_next = {4'b0101, in_rw, in_ra, in_imm[7:0]}; end
              3'd6: begin
                // LI16: low half now, high half latched for the LI2 cycle.
                we_next       = 1'b1;
                wd_next       = {4'b0100, in_rw, in_rw, in_imm[7:0]};
                li_rw_next    = in_rw;
                li_hi_next    = in_imm[15:8];
                fin_pend_next = fin;
                state_next    = LI2;
              end
              default: err_next = 1'b1;
            endcase
          end
          // fin is honoured after any same-cycle instruction (deferred for LI16).
          if (fin && state_next == RUN) state_next = END_ST;
        end
      end
      LI2: begin
        fin_pend_next = 1'b0;
        if (full) begin
          // Only one free word was left for the pair: LIH is dropped.
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          we_next    = 1'b1;
          wd_next    = {4'b0101, li_rw_reg, li_rw_reg, li_hi_reg};
          state_next = (fin_pend_reg || fin) ? END_ST : RUN;
        end
      end
`ifdef ENC_AUTOHALT_EN
      TAIL: begin
        if (full) begin
          err_next = 1'b1;
        end else begin
          we_next = 1'b1;
          wd_next = 16'h0001;
        end
        state_next = DONE;
      end
`endif
      DONE: begin
      end
      default: state_next = RUN;
    endcase

    count_next = we_next ? (count_reg + ONE) : count_reg;
    // While idle the address shows the next slot, saturating at the top.
    addr_next  = we_next ? count_reg[AW-1:0] : (full ? {AW{1'b1}} : count_reg[AW-1:0]);
    done_next  = (state_next == DONE);
    ready_next = (state_next == RUN) && (count_next != FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      fin_pend_reg <= 1'b0;
      li_rw_reg    <= 2'b00;
      li_hi_reg    <= 8'h00;
      im_we_reg    <= 1'b0;
      im_addr_reg  <= {AW{1'b0}};
      im_wd_reg    <= 16'h0000;
      count_reg    <= {(AW+1){1'b0}};
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      fin_pend_reg <= fin_pend_next;
      li_rw_reg    <= li_rw_next;
      li_hi_reg    <= li_hi_next;
      im_we_reg    <= we_next;
      im_addr_reg  <= addr_next;
      im_wd_reg    <= wd_next;
      count_reg    <= count_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
      in_ready_reg <= ready_next;
    end
  end

endmodule

// File: tb/tb_insn_enc_loader.sv
// Testbench for insn_enc_loader (AW=2, 4-word memory so overflow is reachable).
// Queue-based reference model plus per-cycle compare and directed literal checks.
module tb_insn_enc_loader;

  localparam int AW  = 2;
  localparam int CAP = 1 << AW;
`ifdef ENC_AUTOHALT_EN
  localparam bit AUTOHALT = 1'b1;
`else
  localparam bit AUTOHALT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [1:0]    in_rw, in_ra, in_rb;
  logic [2:0]    in_op;
  logic [15:0]   in_imm;
  logic          fin;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [15:0]   im_wd;
  logic [AW:0]   count;
  logic          done;
  logic          err;

  int n_tests = 0;
  int n_fail  = 0;

  insn_enc_loader #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rw(in_rw), .in_ra(in_ra), .in_rb(in_rb),
    .in_op(in_op), .in_imm(in_imm), .fin(fin), .im_we(im_we),
    .im_addr(im_addr), .im_wd(im_wd), .count(count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_count;
  bit          m_closed, m_err, m_fin_req, m_tail_done;
  logic [15:0] m_q[$];
  logic        e_we, e_rdy;
  logic [31:0] e_addr;
  logic [15:0] e_wd;

  task automatic model_reset();
    m_count = 0; m_closed = 0; m_err = 0; m_fin_req = 0; m_tail_done = 0;
    m_q.delete();
    e_we = 0; e_rdy = 1; e_addr = 0; e_wd = 16'h0000;
  endtask

  task automatic emit(input logic [15:0] w);
    e_we = 1; e_addr = m_count; e_wd = w; m_count++;
  endtask

  task automatic close_or_tail();
    if (AUTOHALT && !m_tail_done) begin
      m_q.push_back(16'h0001);
      m_tail_done = 1;
    end else begin
      m_closed = 1;
    end
  endtask

  task automatic model_step();
    int rw, ra, rb, op, imm;
    rw = in_rw; ra = in_ra; rb = in_rb; op = in_op; imm = in_imm;
    e_we = 0;
    if (!m_closed) begin
      if (m_q.size() > 0) begin
        logic [15:0] w;
        w = m_q.pop_front();
        if (fin) m_fin_req = 1;
        if (m_count == CAP) begin
          m_err = 1; m_closed = 1; m_q.delete();
        end else begin
          emit(w);
        end
        if (!m_closed && m_q.size() == 0 && m_fin_req) close_or_tail();
      end else if (m_count == CAP) begin
        m_err = 1; m_closed = 1;
      end else begin
        if (in_valid && e_rdy) begin
          case (in_kind)
            3'd0: emit(16'h0000);
            3'd1: emit(16'h0001);
            3'd2: emit(16'((rw << 10) + (ra << 8) + (op << 4) + 4 + rb));
            3'd3: if (op > 1) m_err = 1;
                  else emit(16'(32'h2000 + (op << 12) + (rw << 10) + (ra << 8) + (imm % 256)));
            3'd4: emit(16'(32'h4000 + (rw << 10) + (ra << 8) + (imm % 256)));
            3'd5: emit(16'(32'h5000 + (rw << 10) + (ra << 8) + (imm % 256)));
            3'd6: begin
              emit(16'(32'h4000 + (rw << 10) + (rw << 8) + (imm % 256)));
              m_q.push_back(16'(32'h5000 + (rw << 10) + (rw << 8) + (imm / 256)));
            end
            default: m_err = 1;
          endcase
        end
        if (fin) begin
          m_fin_req = 1;
          if (m_q.size() == 0) close_or_tail();
        end
      end
    end
    if (!e_we) e_addr = (m_count >= CAP) ? CAP - 1 : m_count;
    e_rdy = !m_closed && m_q.size() == 0 && m_count < CAP;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("im_we",    32'(im_we),    32'(e_we));
      check("im_addr",  32'(im_addr),  e_addr);
      check("im_wd",    32'(im_wd),    32'(e_wd));
      check("count",    32'(count),    32'(m_count));
      check("done",     32'(done),     32'(m_closed));
      check("err",      32'(err),      32'(m_err));
      check("in_ready", 32'(in_ready), 32'(e_rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [2:0] k, input logic [1:0] rw,
                      input logic [1:0] ra, input logic [1:0] rb, input logic [2:0] op,
                      input logic [15:0] imm, input logic f);
    @(negedge clk);
    in_valid = v; in_kind = k; in_rw = rw; in_ra = ra; in_rb = rb;
    in_op = op; in_imm = imm; fin = f;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0; fin = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_kind = 0; in_rw = 0; in_ra = 0; in_rb = 0;
    in_op = 0; in_imm = 0; fin = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count",    32'(count),    32'd0);
    check("rst_done",     32'(done),     32'd0);

    // 1: CALRR rw=1 ra=2 op=3 rb=3
    step(1, 3'd2, 2'd1, 2'd2, 2'd3, 3'd3, 16'h0000, 0);
    after_edge();
    check("t1_we",    32'(im_we),   32'd1);
    check("t1_addr",  32'(im_addr), 32'd0);
    check("t1_wd",    32'(im_wd),   32'h0637);
    check("t1_count", 32'(count),   32'd1);
    idle();

    // 2: LI16 rw=2 imm=A55A
    do_reset();
    step(1, 3'd6, 2'd2, 2'd0, 2'd0, 3'd0, 16'hA55A, 0);
    after_edge();
    check("t2_lil_addr", 32'(im_addr),  32'd0);
    check("t2_lil_wd",   32'(im_wd),    32'h4A5A);
    check("t2_busy",     32'(in_ready), 32'd0);
    idle();
    after_edge();
    check("t2_lih_we",   32'(im_we),    32'd1);
    check("t2_lih_addr", 32'(im_addr),  32'd1);
    check("t2_lih_wd",   32'(im_wd),    32'h5AA5);
    check("t2_ready",    32'(in_ready), 32'd1);

    // 3: illegal CALIM op=2, then legal CALIM
    do_reset();
    step(1, 3'd3, 2'd0, 2'd1, 2'd0, 3'd2, 16'h007F, 0);
    after_edge();
    check("t3_nowe", 32'(im_we), 32'd0);
    check("t3_err",  32'(err),   32'd1);
    step(1, 3'd3, 2'd0, 2'd1, 2'd0, 3'd1, 16'h007F, 0);
    after_edge();
    check("t3_we",   32'(im_we), 32'd1);
    check("t3_wd",   32'(im_wd), 32'h317F);
    idle();

    // 4: fill the 4-word memory, then a 5th valid
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000, 0);
    step(1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000, 0);
    repeat (2) after_edge();
    check("t4_ready", 32'(in_ready), 32'd0);
    check("t4_err",   32'(err),      32'd1);
    check("t4_done",  32'(done),     32'd1);
    check("t4_count", 32'(count),    32'd4);
    idle();

    // 5: HALT with fin in the same cycle at address 1
    do_reset();
    step(1, 3'd0, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000, 0);
    step(1, 3'd1, 2'd0, 2'd0, 2'd0, 3'd0, 16'h0000, 1);
    after_edge();
    check("t5_addr", 32'(im_addr), 32'd1);
    check("t5_wd",   32'(im_wd),   32'h0001);
    if (AUTOHALT) begin
      check("t5_notdone", 32'(done), 32'd0);
      idle();
      after_edge();
      check("t5_tail_addr", 32'(im_addr), 32'd2);
      check("t5_tail_wd",   32'(im_wd),   32'h0001);
    end
    check("t5_done", 32'(done), 32'd1);
    idle();

    // 6: reset while the LIH word is pending
    do_reset();
    step(1, 3'd6, 2'd3, 2'd0, 2'd0, 3'd0, 16'h1234, 0);
    after_edge();
    #2 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t6_count", 32'(count),    32'd0);
    check("t6_addr",  32'(im_addr),  32'd0);
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_we",    32'(im_we),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    after_edge();
    check("t6_no_lih", 32'(im_we), 32'd0);

    // Randomised programs
    for (int p = 0; p < 60; p++) begin
      int len;
      do_reset();
      len = $urandom_range(3, 14);
      for (int c = 0; c < len; c++) begin
        step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom),
             2'($urandom), 2'($urandom), 3'($urandom), 16'($urandom),
             $urandom_range(0, 11) == 0);
      end
      idle();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #3 rst = 1'b1;
      end
      repeat (3) idle();
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
